// File: rtl/mux_rotator_pkg.sv
// Shared mode encoding and select helper for the mux_rotator block.
package mux_rotator_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

  // An out-of-range select collapses to channel 0 when rotation picks it up.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned n);
    return (sel >= n) ? 32'd0 : sel;
  endfunction

endpackage

// File: rtl/mux_rotator_prescaler.sv
// Free-running divider that emits a one-cycle step pulse every TICK_DIV enabled cycles.
module mux_rotator_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic step
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Hold beats clear so a frozen count survives until hold is released.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (!hold) begin
      if (clear) begin
        cnt_d = '0;
      end else if (cnt_q == Last) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_rotator.sv
// NUM_IN-to-1 registered channel selector with manual and prescaled rotate modes.
// Optional MUX_ROTATOR_DIR_EN adds a dir input for downward rotation.
module mux_rotator
  import mux_rotator_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned NUM_IN   = 5,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    hold,
`ifdef MUX_ROTATOR_DIR_EN
  input  logic                    dir,
`endif
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap
);

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] cur_sel_q, cur_sel_d, base;
  logic [WIDTH-1:0] out_q, out_d, chan_sel;
  logic             wrap_q, wrap_d;
  logic             step, down;

`ifdef MUX_ROTATOR_DIR_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  mux_rotator_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (mode == MODE_MANUAL),
    .hold  (hold),
    .step  (step)
  );

  always_comb begin
    base      = SEL_W'(clamp_sel(32'(cur_sel_q), NUM_IN));
    cur_sel_d = cur_sel_q;
    wrap_d    = 1'b0;
    if (!hold) begin
      if (mode == MODE_ROTATE) begin
        cur_sel_d = base;
        if (step) begin
          if (down) begin
            cur_sel_d = (base == '0) ? LastSel : base - 1'b1;
            wrap_d    = (base == '0);
          end else begin
            cur_sel_d = (base >= LastSel) ? '0 : base + 1'b1;
            wrap_d    = (base >= LastSel);
          end
        end
      end else begin
        cur_sel_d = sel;
      end
    end
  end

  // Unmatched (out-of-range) selects fall through to zero.
  always_comb begin
    chan_sel = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (cur_sel_d == SEL_W'(k)) chan_sel = in[k*WIDTH +: WIDTH];
    end
    out_d = hold ? out_q : chan_sel;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_sel_q <= '0;
      out_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      cur_sel_q <= cur_sel_d;
      out_q     <= out_d;
      wrap_q    <= wrap_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_rotator.sv
// Bench for mux_rotator: directed scenarios plus randomized traffic against an integer model.
module tb_mux_rotator;

  localparam int unsigned WIDTH    = 3;
  localparam int unsigned NUM_IN   = 5;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned TICK_DIV = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_IN*WIDTH-1:0] in;
  logic [SEL_W-1:0]        sel;
  logic                    mode, hold, dir;
  logic [WIDTH-1:0]        out;
  logic [SEL_W-1:0]        cur_sel;
  logic                    wrap;

  int total = 0;
  int bad   = 0;
  int m_cur, m_pre, m_out, m_wrap;
  int wraps;

  always #5 clock = ~clock;

  mux_rotator #(
    .WIDTH    (WIDTH),
    .NUM_IN   (NUM_IN),
    .SEL_W    (SEL_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in),
    .sel     (sel),
    .mode    (mode),
    .hold    (hold),
`ifdef MUX_ROTATOR_DIR_EN
    .dir     (dir),
`endif
    .out     (out),
    .cur_sel (cur_sel),
    .wrap    (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int chan(input int k);
    logic [NUM_IN*WIDTH-1:0] t;
    t = in >> (k * WIDTH);
    return int'(t[WIDTH-1:0]);
  endfunction

  function automatic bit rot_down();
`ifdef MUX_ROTATOR_DIR_EN
    return dir;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural view: channel index arithmetic modulo NUM_IN, prescaler modulo TICK_DIV.
  task automatic model_edge();
    int b;
    if (reset) begin
      m_cur = 0; m_pre = 0; m_out = 0; m_wrap = 0;
    end else if (hold) begin
      m_wrap = 0;
    end else if (!mode) begin
      m_cur  = int'(sel);
      m_pre  = 0;
      m_wrap = 0;
      m_out  = (m_cur < NUM_IN) ? chan(m_cur) : 0;
    end else begin
      b      = (m_cur >= NUM_IN) ? 0 : m_cur;
      m_wrap = 0;
      m_pre  = (m_pre + 1) % TICK_DIV;
      if (m_pre == 0) begin
        if (rot_down()) begin
          m_wrap = (b == 0);
          b      = (b + NUM_IN - 1) % NUM_IN;
        end else begin
          b      = (b + 1) % NUM_IN;
          m_wrap = (b == 0);
        end
      end
      m_cur = b;
      m_out = chan(b);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check("out", 32'(out), m_out);
    check("cur_sel", 32'(cur_sel), m_cur);
    check("wrap", 32'(wrap), m_wrap);
    if (wrap) wraps++;
  endtask

  initial begin
    in    = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    sel   = '0;
    mode  = 1'b0;
    hold  = 1'b0;
    dir   = 1'b0;
    wraps = 0;
    m_cur = 0; m_pre = 0; m_out = 0; m_wrap = 0;

    // Reset held for two edges
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_cur", 32'(cur_sel), 0);
    check("rst_wrap", 32'(wrap), 0);
    repeat (2) cycle();
    reset = 1'b0;

    // Manual select, including out-of-range
    sel = 3'd3;
    cycle();
    check("man3_out", 32'(out), 3);
    check("man3_cur", 32'(cur_sel), 3);
    sel = 3'd6;
    cycle();
    check("man6_out", 32'(out), 0);
    check("man6_cur", 32'(cur_sel), 6);

    // Full rotation from channel 0
    sel = 3'd0;
    cycle();
    mode  = 1'b1;
    wraps = 0;
    for (int i = 0; i < 4 * NUM_IN; i++) cycle();
    check("rot_wraps", 32'(wraps), 1);
    check("rot_end_cur", 32'(cur_sel), 0);

    // Hold at channel 2 with prescaler mid-count
    repeat (10) cycle();
    hold = 1'b1;
    repeat (10) cycle();
    check("hold_out", 32'(out), 2);
    check("hold_cur", 32'(cur_sel), 2);
    hold = 1'b0;
    cycle();
    check("resume_cur_a", 32'(cur_sel), 2);
    cycle();
    check("resume_cur_b", 32'(cur_sel), 3);

    // Asynchronous reset mid-rotation
    repeat (2) cycle();
    #3;
    reset = 1'b1;
    m_cur = 0; m_pre = 0; m_out = 0; m_wrap = 0;
    #1;
    check("arst_out", 32'(out), 0);
    check("arst_cur", 32'(cur_sel), 0);
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    check("post_rst_cur_a", 32'(cur_sel), 0);
    cycle();
    check("post_rst_cur_b", 32'(cur_sel), 1);

`ifdef MUX_ROTATOR_DIR_EN
    // Downward rotation from channel 1
    mode = 1'b0;
    sel  = 3'd1;
    cycle();
    mode = 1'b1;
    dir  = 1'b1;
    repeat (4) cycle();
    check("down_cur0", 32'(cur_sel), 0);
    repeat (4) cycle();
    check("down_cur4", 32'(cur_sel), 4);
    check("down_wrap", 32'(wrap), 1);
    repeat (4) cycle();
    check("down_cur3", 32'(cur_sel), 3);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in   = (NUM_IN * WIDTH)'($urandom);
      sel  = SEL_W'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
